phase_shift_dps_ctrl: RTL and testbench

Dynamic phase-shift (DPS) controller for the PLL/MMCM behavioural models. It accepts PSEN/PSINCDEC step requests, paces them with a fixed PSDONE latency and keeps a saturating signed step count. It drives the `shift` input of the phase_shift datapath as thousandths of a degree. It sits between the user-facing DPS ports and the per-output phase_shift instance, and gates all requests on LOCKED.

---
 rtl/phase_shift_dps_ctrl.sv | 131 +++++++++++++
 tb/tb_phase_shift_dps_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_dps_ctrl.sv
// Dynamic phase-shift controller: paces PSEN/PSINCDEC steps with a fixed PSDONE
// latency, keeps a saturating signed step count and converts it to millidegrees.
module phase_shift_dps_ctrl #(
  parameter int DONE_LATENCY  = 12,
  parameter int MAX_STEPS     = 1023,
  parameter int CLKOUT_DIVIDE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               LOCKED,
  input  logic               PSEN,
  input  logic               PSINCDEC,
  output logic               PSDONE,
  output logic               busy,
  output logic               ps_err,
  output logic signed [31:0] shift_steps,
  output logic signed [31:0] shift_deg_1000,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // cnt holds the number of WAIT edges still to pass before the DONE edge,
  // so PSDONE lands exactly DONE_LATENCY edges after the accepting edge.
  localparam logic [7:0]         CNT_LOAD = 8'(DONE_LATENCY - 1);
  localparam logic signed [31:0] MAX_S    = 32'(MAX_STEPS);
  localparam logic signed [63:0] DENOM    = 64'(7 * CLKOUT_DIVIDE);
  localparam logic signed [63:0] NUMER    = 64'sd45000;

  state_t             state, state_next;
  logic [7:0]         cnt, cnt_next;
  logic               dir, dir_next;
  logic               psdone_next, busy_next, err_next;
  logic signed [31:0] steps_next, step_val;
  logic signed [63:0] deg_prod;

  // Saturating +/-1 on the current count; at the limit the count simply holds.
  always_comb begin
    step_val = shift_steps;
    if (dir) begin
      if (shift_steps < MAX_S) step_val = shift_steps + 32'sd1;
    end else begin
      if (shift_steps > -MAX_S) step_val = shift_steps - 32'sd1;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    dir_next    = dir;
    psdone_next = 1'b0;
    busy_next   = busy;
    err_next    = ps_err;
    steps_next  = shift_steps;
    case (state)
      ST_IDLE: begin
        if (PSEN) begin
          if (LOCKED) begin
            state_next = ST_WAIT;
            dir_next   = PSINCDEC;
            cnt_next   = CNT_LOAD;
            busy_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (PSEN) err_next = 1'b1;
        if (!LOCKED) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else if (cnt == 8'd0) begin
          state_next  = ST_DONE;
          psdone_next = 1'b1;
          steps_next  = step_val;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      ST_DONE: begin
        // Leaving DONE is the earliest point a new request may be taken.
        if (PSEN && LOCKED) begin
          state_next = ST_WAIT;
          dir_next   = PSINCDEC;
          cnt_next   = CNT_LOAD;
          busy_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          if (PSEN) err_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      dir         <= 1'b0;
      PSDONE      <= 1'b0;
      busy        <= 1'b0;
      ps_err      <= 1'b0;
      shift_steps <= 32'sd0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      dir         <= dir_next;
      PSDONE      <= psdone_next;
      busy        <= busy_next;
      ps_err      <= err_next;
      shift_steps <= steps_next;
    end
  end

  // steps * 360000 / (56 * DIV) reduced to steps * 45000 / (7 * DIV); signed
  // division truncates toward zero.
  assign deg_prod       = 64'(shift_steps) * NUMER;
  assign shift_deg_1000 = 32'(deg_prod / DENOM);
  assign dbg_state      = state;

endmodule

// File: tb/tb_phase_shift_dps_ctrl.sv
// Bench for phase_shift_dps_ctrl: a default instance and a MAX_STEPS=3 instance
// share stimulus; a negedge monitor checks every PSDONE against expected queues.
module tb_phase_shift_dps_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, locked, psen, incdec;
  logic done_a, busy_a, err_a, done_b, busy_b, err_b;
  logic signed [31:0] steps_a, deg_a, steps_b, deg_b;
  logic [1:0] st_a, st_b;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  int busy_cnt = 0;
  int lat = 0;
  int c0 = 0;

  phase_shift_dps_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .LOCKED(locked), .PSEN(psen), .PSINCDEC(incdec),
    .PSDONE(done_a), .busy(busy_a), .ps_err(err_a),
    .shift_steps(steps_a), .shift_deg_1000(deg_a), .dbg_state(st_a)
  );

  phase_shift_dps_ctrl #(.MAX_STEPS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .LOCKED(locked), .PSEN(psen), .PSINCDEC(incdec),
    .PSDONE(done_b), .busy(busy_b), .ps_err(err_b),
    .shift_steps(steps_b), .shift_deg_1000(deg_b), .dbg_state(st_b)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every PSDONE pops one expected {steps, deg} entry.
  always @(negedge clk) begin
    logic [63:0] e;
    if (done_a) begin
      done_cnt_a++;
      check("psdone_a_width", 32'(prev_a), 0);
      if (exp_a_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_psdone_a: got PSDONE expected none, steps=%0d", steps_a);
      end else begin
        e = exp_a_q.pop_front();
        check("sb_steps_a", steps_a, e[63:32]);
        check("sb_deg_a", deg_a, e[31:0]);
      end
    end
    if (done_b) begin
      done_cnt_b++;
      check("psdone_b_width", 32'(prev_b), 0);
      if (exp_b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_psdone_b: got PSDONE expected none, steps=%0d", steps_b);
      end else begin
        e = exp_b_q.pop_front();
        check("sb_steps_b", steps_b, e[63:32]);
        check("sb_deg_b", deg_b, e[31:0]);
      end
    end
    prev_a = done_a;
    prev_b = done_b;
  end

  task automatic push(input logic signed [31:0] as, input logic signed [31:0] ad,
                      input logic signed [31:0] bs, input logic signed [31:0] bd);
    exp_a_q.push_back({as, ad});
    exp_b_q.push_back({bs, bd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    psen  = 1'b0;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask

  // PSEN is sampled at the posedge inside this task (edge N).
  task automatic issue(input logic dir);
    @(negedge clk);
    psen   = 1'b1;
    incdec = dir;
    @(posedge clk);
    #1;
    psen     = 1'b0;
    busy_cnt = busy_a ? 1 : 0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy_a) busy_cnt++;
      if (done_a) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic step(input logic dir,
                      input logic signed [31:0] as, input logic signed [31:0] ad,
                      input logic signed [31:0] bs, input logic signed [31:0] bd);
    push(as, ad, bs, bd);
    issue(dir);
    wait_done(lat);
    check("psdone_latency", lat, 12);
  endtask

  int inc_a_deg[7] = '{6428, 12857, 19285, 25714, 32142, 38571, 45000};
  int inc_b_s[7]   = '{1, 2, 3, 3, 3, 3, 3};
  int inc_b_d[7]   = '{6428, 12857, 19285, 19285, 19285, 19285, 19285};
  int dec_a_d[5]   = '{-6428, -12857, -19285, -25714, -32142};
  int dec_b_s[5]   = '{-1, -2, -3, -3, -3};
  int dec_b_d[5]   = '{-6428, -12857, -19285, -19285, -19285};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; locked = 1'b0; psen = 1'b0; incdec = 1'b0;
    // Reset values and lock gating.
    #8;
    check("rst_psdone", 32'(done_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_steps", steps_a, 0);
    check("rst_deg", deg_a, 0);
    check("rst_state", 32'(st_a), 0);
    #2;
    rst_n = 1'b1;
    c0 = done_cnt_a;
    issue(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("unlocked_no_done", done_cnt_a - c0, 0);
    check("unlocked_steps", steps_a, 0);
    check("unlocked_err", 32'(err_a), 1);
    check("unlocked_busy", 32'(busy_a), 0);

    // Single increment: latency, pulse width, busy length, conversion.
    do_reset();
    locked = 1'b1;
    step(1'b1, 1, 6428, 1, 6428);
    check("single_busy_at_done", 32'(busy_a), 1);
    @(posedge clk);
    #1;
    if (busy_a) busy_cnt++;
    check("single_done_drop", 32'(done_a), 0);
    check("single_busy_drop", 32'(busy_a), 0);
    check("single_busy_cycles", busy_cnt, 13);
    check("single_steps", steps_a, 1);
    check("single_deg", deg_a, 6428);
    check("single_err", 32'(err_a), 0);

    // Seven increments then two decrements, back to back.
    do_reset();
    for (int i = 0; i < 7; i++)
      step(1'b1, i + 1, inc_a_deg[i], inc_b_s[i], inc_b_d[i]);
    check("inc7_steps", steps_a, 7);
    check("inc7_deg", deg_a, 45000);
    check("inc7_b_sat_steps", steps_b, 3);
    step(1'b0, 6, 38571, 2, 12857);
    step(1'b0, 5, 32142, 1, 6428);
    check("mix_steps", steps_a, 5);
    check("mix_deg", deg_a, 32142);
    check("mix_err", 32'(err_a), 0);

    // Negative saturation on the MAX_STEPS=3 instance.
    do_reset();
    c0 = done_cnt_b;
    for (int i = 0; i < 5; i++)
      step(1'b0, -(i + 1), dec_a_d[i], dec_b_s[i], dec_b_d[i]);
    repeat (2) @(posedge clk);
    #1;
    check("sat_done_count", done_cnt_b - c0, 5);
    check("sat_steps", steps_b, -3);
    check("sat_deg", deg_b, -19285);
    check("sat_err", 32'(err_b), 0);
    check("unsat_steps", steps_a, -5);

    // Second request while busy is dropped and flagged.
    do_reset();
    c0 = done_cnt_a;
    push(1, 6428, 1, 6428);
    issue(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    psen = 1'b1; incdec = 1'b0;
    @(posedge clk);
    #1;
    psen = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("busy_req_done_count", done_cnt_a - c0, 1);
    check("busy_req_steps", steps_a, 1);
    check("busy_req_err", 32'(err_a), 1);

    // LOCKED dropped mid-WAIT aborts without touching the count.
    do_reset();
    step(1'b1, 1, 6428, 1, 6428);
    repeat (2) @(posedge clk);
    c0 = done_cnt_a;
    issue(1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    locked = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_done", 32'(done_a), 0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_done_count", done_cnt_a - c0, 0);
    check("abort_steps", steps_a, 1);
    locked = 1'b1;

    // Asynchronous reset mid-WAIT clears everything at once.
    do_reset();
    step(1'b1, 1, 6428, 1, 6428);
    repeat (2) @(posedge clk);
    issue(1'b1);
    c0 = done_cnt_a;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_a), 0);
    check("arst_done", 32'(done_a), 0);
    check("arst_err", 32'(err_a), 0);
    check("arst_steps", steps_a, 0);
    check("arst_deg", deg_a, 0);
    #3;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_done_count", done_cnt_a - c0, 0);
    check("arst_steps_after", steps_a, 0);

    check("queue_a_empty", exp_a_q.size(), 0);
    check("queue_b_empty", exp_b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
